// File: rtl/interrupt_controller.sv
// Four-source priority interrupt controller.
// Arbitrates level requests and runs the ack/eoi handshake.
module interrupt_controller #(
  parameter logic [7:0] BASE_TRAP  = 8'h20,
  parameter logic [3:0] RESET_MASK = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       cfg_we,
  input  logic [2:0] cfg_addr,
  input  logic [7:0] cfg_wdata,
  input  logic       cpu_ack,
  input  logic       cpu_eoi,
  output logic       irq,
  output logic [7:0] trap_type,
  output logic [3:0] grant,
  output logic       busy,
  output logic [3:0] cur_level
);

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    SERVICE
  } state_t;

  state_t     state, state_n;
  logic [3:0] level [4];
  logic [3:0] mask;
  logic [1:0] win_idx, win_n;

  logic       irq_n;
  logic [7:0] trap_n;
  logic [3:0] grant_n;
  logic       busy_n;
  logic [3:0] cur_n;

  logic [3:0] elig;
  logic       any;
  logic [1:0] best;
  logic [3:0] best_lvl;

  function automatic logic [7:0] vec(input logic [1:0] idx);
    return BASE_TRAP + {4'b0000, idx, 2'b00};
  endfunction

  // Eligibility and highest-level winner, ties to lowest index.
  always_comb begin
    elig     = '0;
    best     = '0;
    best_lvl = '0;
    for (int i = 0; i < 4; i++) begin
      elig[i] = req[i] & ~mask[i] & (level[i] != 4'd0);
    end
    for (int i = 0; i < 4; i++) begin
      if (elig[i] && (level[i] > best_lvl)) begin
        best     = 2'(i);
        best_lvl = level[i];
      end
    end
    any = |elig;
  end

  // Configuration registers: per-source level and mask.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        level[i] <= 4'(i + 1);
      end
      mask <= RESET_MASK;
    end else if (cfg_we) begin
      if (!cfg_addr[2]) begin
        level[cfg_addr[1:0]] <= cfg_wdata[3:0];
      end else if (cfg_addr == 3'd4) begin
        mask <= cfg_wdata[3:0];
      end
    end
  end

  // Next-state and next-output decode for the handshake FSM.
  always_comb begin
    state_n = state;
    win_n   = win_idx;
    irq_n   = irq;
    trap_n  = trap_type;
    grant_n = '0;
    busy_n  = busy;
    cur_n   = cur_level;
    unique case (state)
      IDLE: begin
        if (any) begin
          win_n   = best;
          irq_n   = 1'b1;
          trap_n  = vec(best);
          cur_n   = best_lvl;
          state_n = PEND;
        end
      end
      PEND: begin
        if (cpu_ack) begin
          irq_n          = 1'b0;
          grant_n[win_idx] = 1'b1;
          busy_n         = 1'b1;
          state_n        = SERVICE;
        end else if (!elig[win_idx]) begin
          irq_n   = 1'b0;
          cur_n   = '0;
          state_n = IDLE;
        end else if (best != win_idx &&
                     best_lvl > level[win_idx]) begin
          win_n  = best;
          trap_n = vec(best);
          cur_n  = best_lvl;
        end
      end
      SERVICE: begin
        if (cpu_eoi) begin
          busy_n  = 1'b0;
          cur_n   = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      win_idx   <= '0;
      irq       <= 1'b0;
      trap_type <= BASE_TRAP;
      grant     <= '0;
      busy      <= 1'b0;
      cur_level <= '0;
    end else begin
      state     <= state_n;
      win_idx   <= win_n;
      irq       <= irq_n;
      trap_type <= trap_n;
      grant     <= grant_n;
      busy      <= busy_n;
      cur_level <= cur_n;
    end
  end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Centralised interrupt controller sitting between up to four interrupt-generating devices and the CPU trap logic. It collects level requests from the devices, arbitrates by a programmable 4-bit priority level, and raises a single request to the CPU with the 8-bit trap vector of the winner. It then runs the acknowledge / end-of-interrupt handshake and pulses a per-source `grant` that drives the device's handled input to clear its pending interrupt.

## Interface

Parameters:
- `BASE_TRAP`, default 8'h20: trap vector of source 0. Source i vector = `BASE_TRAP + 4*i`, 8-bit wrap.
- `RESET_MASK`, default 4'b0000: mask register value at reset. 1 = source masked.

Ports:
- `clk`  input  1  clock
- `reset`  input  1  asynchronous, active-high reset
- `req`  input  4  level interrupt requests, bit i = source i
- `cfg_we`  input  1  configuration write strobe
- `cfg_addr`  input  3  0–3 = level of source 0–3; 4 = mask register; 5–7 = writes ignored
- `cfg_wdata`  input  8  write data; level uses [3:0], mask uses [3:0]
- `cpu_ack`  input  1  CPU accepts the pending interrupt
- `cpu_eoi`  input  1  CPU finished servicing the interrupt
- `irq`  output  1  interrupt request to CPU
- `trap_type`  output  8  vector of the current winner or in-service source
- `grant`  output  4  one-hot, one-cycle handled pulse to the serviced source
- `busy`  output  1  high in SERVICE
- `cur_level`  output  4  level of the current winner or in-service source; 0 when IDLE

## Operation

- Registers: `level[i]` (4 bits each), `mask` (4 bits), `win_idx` (2 bits), FSM state.
- Reset values: `level[i] = i+1` (source 3 highest), `mask = RESET_MASK`, state IDLE. Outputs: `irq` 0, `trap_type = BASE_TRAP`, `grant` 0, `busy` 0, `cur_level` 0.
- Eligibility: source i is eligible when `req[i] & ~mask[i] & (level[i] != 0)`. Level 0 disables a source.
- Arbitration (combinational, from registered config): the highest `level` wins. Ties go to the lowest index.
- FSM states:
  - **IDLE**: if any source is eligible, latch the winner's index, level and vector, set `irq`, and go to PEND.
  - **PEND**:
    - If `cpu_ack`: clear `irq`, set `grant[win_idx]` for one cycle, set `busy`, go to SERVICE.
    - Else if the latched winner is no longer eligible (request dropped, masked, or level set to 0): clear `irq`, set `cur_level` to 0, go to IDLE (spurious; no grant).
    - Else if a different eligible source has a strictly higher level: re-latch the winner; `irq` stays high and `trap_type`/`cur_level` update.
  - **SERVICE**: ignore all requests and `cpu_ack`. On `cpu_eoi`: clear `busy`, set `cur_level` to 0, go to IDLE. No nesting.
- `cpu_eoi` outside SERVICE is ignored. `cpu_ack` outside PEND is ignored.
- Config writes take effect at the clock edge and are visible to arbitration from the next cycle. Writing a level during SERVICE does not change the latched `cur_level`.

## Timing

- All outputs are registered.
- Request latency: `req` sampled at edge N gives `irq`/`trap_type` valid after edge N.
- Acknowledge: `cpu_ack` sampled at edge N gives `irq` = 0, `grant` high, `busy` = 1 for cycle N+1. `grant` deasserts after edge N+1.
- `cpu_ack` and a higher-priority arrival in the same cycle: `cpu_ack` wins and the currently latched winner is granted.
- `cpu_ack` and winner drop in the same cycle: the grant is still issued, because the CPU has already committed to the vector.
- EOI: `cpu_eoi` at edge N returns to IDLE after N. The earliest next `irq` is after edge N+1, so there is at least one cycle of `irq` low.
- Reset mid-operation: all state returns to reset values immediately and asynchronously. Any `grant` pulse or `irq` in flight is dropped.

## Test plan

- Reset, then `req`=4'b0001 → `irq` 1 one cycle later, `trap_type` 8'h20, `cur_level` 1. `cpu_ack` → `grant` 4'b0001 for exactly one cycle, `busy` 1. `cpu_eoi` → `busy` 0, `cur_level` 0.
- `req`=4'b0101 simultaneously → winner source 2, `trap_type` 8'h28, `cur_level` 3. Then write level0=4'hF and re-raise source 0 after EOI with source 2 still requesting → `trap_type` 8'h20 wins.
- In PEND on source 1 (`trap_type` 8'h24), assert `req[3]` → `trap_type` becomes 8'h2C with `irq` held high. Assert `cpu_ack` the same cycle as a `req[3]` rise in a second run → source 1 is granted.
- In PEND, drop the winner's `req` → `irq` 0 next cycle, no `grant`, state IDLE. Repeat by writing mask=4'b0010 while source 1 is pending → same result.
- Tie: levels 0 and 2 both 4'h7, `req`=4'b0101 → source 0 wins. During SERVICE toggle `cpu_ack` and new requests → no `irq`, no `grant` until after `cpu_eoi`.
- Assert `reset` while in SERVICE with `req` held → all outputs return to reset values immediately. After `reset` release, `irq` re-asserts one cycle later for the held request.
